// File: rtl/dds_phase_sweep.sv
// dds_phase_sweep: AXI-Stream phase-increment source for dds_top.
// Emits a stepped frequency sweep: step k carries start_pinc + k*step_pinc
// (mod 2^DATA_W), and each step is held for a fixed number of accepted beats.
// Optional feature macro: DDS_PHASE_SWEEP_CONTINUOUS_EN. When it is defined,
// cfg_continuous=1 makes the sweep restart at step 0 after every pass until it
// is aborted. Without it, cfg_continuous is ignored and every sweep is single-shot.
module dds_phase_sweep #(
    parameter int DATA_W  = 32,
    parameter int NSTEP_W = 16,
    parameter int DWELL_W = 16
) (
    input  logic               axis_aclk,
    input  logic               axis_areset,
    input  logic [DATA_W-1:0]  cfg_start_pinc,
    input  logic [DATA_W-1:0]  cfg_step_pinc,
    input  logic [NSTEP_W-1:0] cfg_num_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_continuous,
    input  logic               start,
    input  logic               abort,
    output logic [DATA_W-1:0]  m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tuser,
    output logic               m_axis_tlast,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN
    } state_t;

    state_t             r_state;

    // Configuration captured on start; cfg_* inputs are ignored afterwards.
    logic [DATA_W-1:0]  r_startPinc;
    logic [DATA_W-1:0]  r_stepPinc;
    logic [NSTEP_W-1:0] r_numSteps;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_continuous;

    logic [NSTEP_W-1:0] r_stepCnt;
    logic [DWELL_W-1:0] r_dwellCnt;

    logic [DATA_W-1:0]  r_tdata;
    logic               r_tvalid;
    logic               r_tuser;
    logic               r_tlast;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_lastDwell;
    logic               w_lastStep;
    logic               w_passEnd;
    logic               w_nextStepLast;
    logic               w_nextDwellLast;
    logic [NSTEP_W-1:0] w_nEff;
    logic [DWELL_W-1:0] w_dEff;
    logic               w_cfgCont;

`ifdef DDS_PHASE_SWEEP_CONTINUOUS_EN
    assign w_cfgCont = cfg_continuous;
`else
    logic w_unusedCont;
    assign w_unusedCont = cfg_continuous;
    assign w_cfgCont    = 1'b0;
`endif

    // A zero step count or zero dwell is treated as one.
    assign w_nEff = (cfg_num_steps == '0) ? NSTEP_W'(1) : cfg_num_steps;
    assign w_dEff = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;

    assign w_accept        = r_tvalid & m_axis_tready;
    assign w_lastDwell     = (r_dwellCnt == r_dwell - DWELL_W'(1));
    assign w_lastStep      = (r_stepCnt == r_numSteps - NSTEP_W'(1));
    assign w_passEnd       = w_lastDwell & w_lastStep;
    // These look one beat ahead so that tlast is registered with the beat it marks.
    assign w_nextStepLast  = ((r_stepCnt + NSTEP_W'(1)) == (r_numSteps - NSTEP_W'(1)));
    assign w_nextDwellLast = ((r_dwellCnt + DWELL_W'(1)) == (r_dwell - DWELL_W'(1)));

    // Sweep sequencer: every output is a register updated together with the state.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_state      <= ST_IDLE;
            r_startPinc  <= '0;
            r_stepPinc   <= '0;
            r_numSteps   <= '0;
            r_dwell      <= '0;
            r_continuous <= 1'b0;
            r_stepCnt    <= '0;
            r_dwellCnt   <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tuser      <= 1'b0;
            r_tlast      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tvalid <= 1'b0;
                    r_tuser  <= 1'b0;
                    r_tlast  <= 1'b0;
                    r_busy   <= 1'b0;
                    if (start && !abort) begin
                        r_startPinc  <= cfg_start_pinc;
                        r_stepPinc   <= cfg_step_pinc;
                        r_numSteps   <= w_nEff;
                        r_dwell      <= w_dEff;
                        r_continuous <= w_cfgCont;
                        r_stepCnt    <= '0;
                        r_dwellCnt   <= '0;
                        r_tdata      <= cfg_start_pinc;
                        r_tvalid     <= 1'b1;
                        r_tuser      <= 1'b1;
                        r_tlast      <= (w_nEff == NSTEP_W'(1)) && (w_dEff == DWELL_W'(1));
                        r_busy       <= 1'b1;
                        r_state      <= ST_SWEEP;
                    end
                end

                ST_SWEEP: begin
                    if (w_accept) begin
                        if (abort || (w_passEnd && !r_continuous)) begin
                            r_state  <= ST_IDLE;
                            r_tvalid <= 1'b0;
                            r_tuser  <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else if (w_passEnd) begin
                            r_stepCnt  <= '0;
                            r_dwellCnt <= '0;
                            r_tdata    <= r_startPinc;
                            r_tuser    <= 1'b1;
                            r_tlast    <= (r_numSteps == NSTEP_W'(1)) && (r_dwell == DWELL_W'(1));
                        end else if (w_lastDwell) begin
                            r_stepCnt  <= r_stepCnt + NSTEP_W'(1);
                            r_dwellCnt <= '0;
                            r_tdata    <= r_tdata + r_stepPinc;
                            r_tuser    <= 1'b1;
                            r_tlast    <= w_nextStepLast && (r_dwell == DWELL_W'(1));
                        end else begin
                            r_dwellCnt <= r_dwellCnt + DWELL_W'(1);
                            r_tuser    <= 1'b0;
                            r_tlast    <= w_lastStep && w_nextDwellLast;
                        end
                    end else if (abort) begin
                        r_state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (w_accept) begin
                        r_state  <= ST_IDLE;
                        r_tvalid <= 1'b0;
                        r_tuser  <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_dds_phase_sweep.sv
// tb_dds_phase_sweep: scoreboard bench for dds_phase_sweep.
// Each start pushes the full expected pass (computed from start + k*step) into a
// queue; a negedge monitor pops on every accepted beat and also checks stall
// stability and the done pulse.
`timescale 1ns/1ps
module tb_dds_phase_sweep;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] cfgStartPinc;
    logic [31:0] cfgStepPinc;
    logic [15:0] cfgNumSteps;
    logic [15:0] cfgDwell;
    logic        cfgContinuous;
    logic        startPulse;
    logic        abortPulse;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [31:0] data;
        logic        user;
        logic        last;
    } beat_t;

    beat_t       qExp[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] mStart;
    logic [31:0] mStep;
    int          mN;
    int          mD;
    bit          mCont = 1'b0;
    bit          abortSeen = 1'b0;
    bit          expDone = 1'b0;
    bit          stallHeld = 1'b0;
    beat_t       stallBeat;
    beat_t       popped;
    int          cyc;

    dds_phase_sweep dut (
        .axis_aclk      (clock),
        .axis_areset    (reset),
        .cfg_start_pinc (cfgStartPinc),
        .cfg_step_pinc  (cfgStepPinc),
        .cfg_num_steps  (cfgNumSteps),
        .cfg_dwell      (cfgDwell),
        .cfg_continuous (cfgContinuous),
        .start          (startPulse),
        .abort          (abortPulse),
        .m_axis_tdata   (tdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tuser   (tuser),
        .m_axis_tlast   (tlast),
        .busy           (busy),
        .done           (done)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One sweep pass straight from the definition: step k holds start+k*step for D beats.
    function automatic void pushPass();
        for (int k = 0; k < mN; k++) begin
            for (int d = 0; d < mD; d++) begin
                beat_t b;
                b.data = mStart + 32'(k) * mStep;
                b.user = (d == 0);
                b.last = (k == mN - 1) && (d == mD - 1);
                qExp.push_back(b);
            end
        end
    endfunction

    // Monitor: samples at negedge, scoring accepted beats, stalls and done.
    always @(negedge clock) begin
        if (reset) begin
            qExp.delete();
            abortSeen = 1'b0;
            expDone   = 1'b0;
            stallHeld = 1'b0;
        end else begin
            checkOutput("done_pulse", 32'(done), 32'(expDone));
            expDone = 1'b0;
            if (stallHeld) begin
                checkOutput("stall_tvalid", 32'(tvalid), 32'd1);
                checkOutput("stall_tdata", tdata, stallBeat.data);
                checkOutput("stall_flags", {30'd0, tuser, tlast}, {30'd0, stallBeat.user, stallBeat.last});
                stallHeld = 1'b0;
            end
            if (tvalid) begin
                checkOutput("busy_with_valid", 32'(busy), 32'd1);
                if (qExp.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL extra_beat: got beat tdata=0x%08h expected no beat", tdata);
                end else if (tready) begin
                    popped = qExp.pop_front();
                    checkOutput("beat_tdata", tdata, popped.data);
                    checkOutput("beat_tuser", 32'(tuser), 32'(popped.user));
                    checkOutput("beat_tlast", 32'(tlast), 32'(popped.last));
                    if (abortPulse || abortSeen) begin
                        qExp.delete();
                        abortSeen = 1'b0;
                        expDone   = 1'b1;
                    end else if (popped.last) begin
                        if (mCont) pushPass();
                        else expDone = 1'b1;
                    end
                end else begin
                    stallBeat = '{data: tdata, user: tuser, last: tlast};
                    stallHeld = 1'b1;
                    if (abortPulse) abortSeen = 1'b1;
                end
            end
        end
    end

    // Latch a new configuration into the model and pulse start for one cycle.
    task automatic issueStart(input logic [31:0] sp, input logic [31:0] st, input int n, input int d, input bit cont);
        cfgStartPinc  = sp;
        cfgStepPinc   = st;
        cfgNumSteps   = 16'(n);
        cfgDwell      = 16'(d);
        cfgContinuous = cont;
        mStart = sp;
        mStep  = st;
        mN     = (n == 0) ? 1 : n;
        mD     = (d == 0) ? 1 : d;
`ifdef DDS_PHASE_SWEEP_CONTINUOUS_EN
        mCont  = cont;
`else
        mCont  = 1'b0;
`endif
        pushPass();
        startPulse = 1'b1;
        @(posedge clock); #1;
        startPulse = 1'b0;
        checkOutput("first_beat_valid", 32'(tvalid), 32'd1);
        checkOutput("first_beat_tdata", tdata, sp);
    endtask

    // Run one full sweep; mode 0 = ready high, 1 = toggle, 2 = random.
    task automatic applyStimulus(input logic [31:0] sp, input logic [31:0] st, input int n, input int d,
                                 input bit cont, input int mode, input bit noise, output int cycles);
        issueStart(sp, st, n, d, cont);
        cycles = 0;
        while (busy && cycles < 2000) begin
            case (mode)
                0:       tready = 1'b1;
                1:       tready = (cycles % 2 == 0);
                default: tready = 1'($urandom_range(0, 1));
            endcase
            if (noise && cycles == 3) begin
                startPulse   = 1'b1;
                cfgStartPinc = $urandom;
                cfgStepPinc  = $urandom;
                cfgNumSteps  = 16'($urandom_range(1, 9));
                cfgDwell     = 16'($urandom_range(1, 9));
            end else begin
                startPulse = 1'b0;
            end
            cycles++;
            @(posedge clock); #1;
        end
        startPulse = 1'b0;
        if (busy) begin
            total++;
            bad++;
            $display("[TB] FAIL sweep_timeout: got busy after %0d cycles expected idle", cycles);
        end
        tready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("pending_beats", 32'(qExp.size()), 32'd0);
        checkOutput("busy_after_sweep", 32'(busy), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        cfgStartPinc  = '0;
        cfgStepPinc   = '0;
        cfgNumSteps   = '0;
        cfgDwell      = '0;
        cfgContinuous = 1'b0;
        startPulse    = 1'b0;
        abortPulse    = 1'b0;
        tready        = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_tvalid", 32'(tvalid), 32'd0);
        checkOutput("reset_tdata", tdata, 32'd0);
        checkOutput("reset_flags", {29'd0, tuser, tlast, busy}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Basic four-step sweep with continuous ready: 8 beats.
        applyStimulus(32'h0040_0000, 32'h0010_0000, 4, 2, 1'b0, 0, 1'b0, cyc);
        checkOutput("basic_cycles", 32'(cyc), 32'd8);

        // Wrap-around of the phase increment.
        applyStimulus(32'hFFC0_0000, 32'h0020_0000, 3, 1, 1'b0, 0, 1'b0, cyc);
        checkOutput("wrap_cycles", 32'(cyc), 32'd3);

        // Ready toggling: same beats, 15 cycles in sweep.
        applyStimulus(32'h0040_0000, 32'h0010_0000, 4, 2, 1'b0, 1, 1'b0, cyc);
        checkOutput("toggle_cycles", 32'(cyc), 32'd15);

        // Zero step count and dwell both behave as one: a single beat.
        applyStimulus(32'h1234_5678, 32'h0000_0001, 0, 0, 1'b0, 0, 1'b0, cyc);
        checkOutput("zero_cfg_cycles", 32'(cyc), 32'd1);

        // Abort on beat 3 while stalled for 5 cycles.
        issueStart(32'h0040_0000, 32'h0010_0000, 4, 2, 1'b0);
        tready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tready     = 1'b0;
        abortPulse = 1'b1;
        @(posedge clock); #1;
        abortPulse = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checkOutput("drain_busy", 32'(busy), 32'd1);
        checkOutput("drain_tdata", tdata, 32'h0050_0000);
        tready = 1'b1;
        @(posedge clock); #1;
        checkOutput("drain_exit_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge clock);
        #1;
        checkOutput("abort_pending", 32'(qExp.size()), 32'd0);

        // Abort with ready high retires immediately.
        issueStart(32'h0100_0000, 32'h0001_0000, 5, 3, 1'b0);
        tready = 1'b1;
        @(posedge clock); #1;
        abortPulse = 1'b1;
        @(posedge clock); #1;
        abortPulse = 1'b0;
        checkOutput("abort_now_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clock);
        #1;

        // Start and abort together in idle: nothing happens.
        cfgStartPinc = 32'hDEAD_BEEF;
        cfgNumSteps  = 16'd2;
        cfgDwell     = 16'd2;
        startPulse   = 1'b1;
        abortPulse   = 1'b1;
        @(posedge clock); #1;
        startPulse   = 1'b0;
        abortPulse   = 1'b0;
        checkOutput("start_abort_tvalid", 32'(tvalid), 32'd0);
        checkOutput("start_abort_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clock);
        #1;

        // Reset in the middle of a stalled sweep, then a fresh sweep.
        issueStart(32'h0040_0000, 32'h0010_0000, 4, 2, 1'b0);
        tready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        checkOutput("midreset_tvalid", 32'(tvalid), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_tdata", tdata, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        applyStimulus(32'h0040_0000, 32'h0010_0000, 4, 2, 1'b0, 2, 1'b0, cyc);

        // Continuous mode (or its single-shot fallback).
`ifdef DDS_PHASE_SWEEP_CONTINUOUS_EN
        tready = 1'b1;
        issueStart(32'h0040_0000, 32'h0010_0000, 2, 1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(posedge clock); #1;
            checkOutput("cont_busy", 32'(busy), 32'd1);
        end
        abortPulse = 1'b1;
        @(posedge clock); #1;
        abortPulse = 1'b0;
        checkOutput("cont_abort_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("cont_pending", 32'(qExp.size()), 32'd0);
        mCont = 1'b0;
`else
        applyStimulus(32'h0040_0000, 32'h0010_0000, 2, 1, 1'b1, 0, 1'b0, cyc);
        checkOutput("cont_ignored_cycles", 32'(cyc), 32'd2);
`endif

        // Randomized sweeps with stray start pulses and cfg churn mid-sweep.
        for (int t = 0; t < 8; t++) begin
            applyStimulus($urandom, $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                          1'b0, int'($urandom_range(0, 2)), 1'b1, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
